// File: rtl/convert_rgb2ycbcr.sv
// RGB888 to BT.601 limited-range 10-bit YCbCr converter: six-stage fixed-latency
// pipeline with optional 4:2:2 pair-averaged chroma.
module convert_rgb2ycbcr #(
    parameter bit CHROMA_422 = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data_r,
    input  logic [7:0] i_data_g,
    input  logic [7:0] i_data_b,
    input  logic       i_de,
    input  logic       i_sync_h,
    input  logic       i_sync_v,
    output logic [9:0] o_data_y,
    output logic [9:0] o_data_cb,
    output logic [9:0] o_data_cr,
    output logic       o_de,
    output logic       o_sync_h,
    output logic       o_sync_v
);

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

    localparam logic signed [21:0] K_RND = 22'sd512;
    localparam logic signed [21:0] K_Y_OFS = 22'sd64;
    localparam logic signed [21:0] K_C_OFS = 22'sd512;

    // Clamp a signed intermediate into the 10-bit output code range.
    function automatic logic [9:0] f_sat10(input logic signed [21:0] v);
        logic [9:0] res;
        if (v < 22'sd0) begin
            res = 10'd0;
        end else if (v > 22'sd1023) begin
            res = 10'd1023;
        end else begin
            res = v[9:0];
        end
        return res;
    endfunction

    function automatic logic [9:0] f_avg10(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b} + 11'd1;
        return s[10:1];
    endfunction

    function automatic logic signed [21:0] f_mul(input logic [7:0] px, input logic signed [21:0] coef);
        return $signed({14'd0, px}) * coef;
    endfunction

    logic [7:0]         r_r1, r_g1, r_b1;
    logic signed [21:0] r_prod [9];
    logic signed [21:0] r_sum_y, r_sum_cb, r_sum_cr;
    logic signed [21:0] r_y4, r_cb4, r_cr4;
    logic [9:0]         r_y5, r_cb5, r_cr5;
    logic [9:0]         r_y6, r_cb6, r_cr6;
    logic [5:0]         r_de_d, r_hs_d, r_vs_d;
    logic [4:0]         r_live;
    phase_t             r_ph;

    logic [9:0]         w_cb_sat4, w_cr_sat4;
    logic [9:0]         w_cb6, w_cr6;
    phase_t             w_ph_next;
    logic               w_pair;

    assign w_cb_sat4 = f_sat10(r_cb4);
    assign w_cr_sat4 = f_sat10(r_cr4);

    // Control delay lines, plus a fill marker so stale zeroed stages never reach the output.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_de_d <= 6'd0;
            r_hs_d <= 6'd0;
            r_vs_d <= 6'd0;
            r_live <= 5'd0;
        end else begin
            r_de_d <= {r_de_d[4:0], i_de};
            r_hs_d <= {r_hs_d[4:0], i_sync_h};
            r_vs_d <= {r_vs_d[4:0], i_sync_v};
            r_live <= {r_live[3:0], 1'b1};
        end
    end

    // Datapath stages S1 (input) through S5 (saturate).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_r1     <= 8'd0;
            r_g1     <= 8'd0;
            r_b1     <= 8'd0;
            for (int k = 0; k < 9; k++) begin
                r_prod[k] <= 22'sd0;
            end
            r_sum_y  <= 22'sd0;
            r_sum_cb <= 22'sd0;
            r_sum_cr <= 22'sd0;
            r_y4     <= 22'sd0;
            r_cb4    <= 22'sd0;
            r_cr4    <= 22'sd0;
            r_y5     <= 10'd0;
            r_cb5    <= 10'd0;
            r_cr5    <= 10'd0;
        end else begin
            r_r1      <= i_data_r;
            r_g1      <= i_data_g;
            r_b1      <= i_data_b;
            // Magnitudes only; coefficient signs are applied in the sum stage.
            r_prod[0] <= f_mul(r_r1, 22'sd1052);
            r_prod[1] <= f_mul(r_g1, 22'sd2065);
            r_prod[2] <= f_mul(r_b1, 22'sd401);
            r_prod[3] <= f_mul(r_r1, 22'sd607);
            r_prod[4] <= f_mul(r_g1, 22'sd1192);
            r_prod[5] <= f_mul(r_b1, 22'sd1799);
            r_prod[6] <= f_mul(r_r1, 22'sd1799);
            r_prod[7] <= f_mul(r_g1, 22'sd1506);
            r_prod[8] <= f_mul(r_b1, 22'sd293);
            r_sum_y   <= r_prod[0] + r_prod[1] + r_prod[2] + K_RND;
            r_sum_cb  <= r_prod[5] - r_prod[3] - r_prod[4] + K_RND;
            r_sum_cr  <= r_prod[6] - r_prod[7] - r_prod[8] + K_RND;
            r_y4      <= (r_sum_y >>> 10) + K_Y_OFS;
            r_cb4     <= (r_sum_cb >>> 10) + K_C_OFS;
            r_cr4     <= (r_sum_cr >>> 10) + K_C_OFS;
            r_y5      <= f_sat10(r_y4);
            r_cb5     <= w_cb_sat4;
            r_cr5     <= w_cr_sat4;
        end
    end

    // Chroma phase state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ph <= PH_EVEN;
        end else begin
            r_ph <= w_ph_next;
        end
    end

    // Phase next-state and S6 chroma selection; an EVEN pixel peeks at its partner in S4.
    always_comb begin
        w_ph_next = PH_EVEN;
        w_pair    = 1'b0;
        w_cb6     = r_cb5;
        w_cr6     = r_cr5;
        if (r_hs_d[4]) begin
            w_ph_next = PH_EVEN;
        end else if (!r_de_d[4]) begin
            w_ph_next = PH_EVEN;
        end else begin
            case (r_ph)
                PH_EVEN: w_ph_next = PH_ODD;
                PH_ODD:  w_ph_next = PH_EVEN;
                default: w_ph_next = PH_EVEN;
            endcase
        end
        w_pair = (r_ph == PH_EVEN) && r_de_d[4] && !r_hs_d[4] && r_de_d[3];
        if (CHROMA_422) begin
            if (w_pair) begin
                w_cb6 = f_avg10(r_cb5, w_cb_sat4);
                w_cr6 = f_avg10(r_cr5, w_cr_sat4);
            end else if ((r_ph == PH_ODD) && r_de_d[4]) begin
                // The partner already loaded the pair average into S6; keep it.
                w_cb6 = r_cb6;
                w_cr6 = r_cr6;
            end else begin
                w_cb6 = r_cb5;
                w_cr6 = r_cr5;
            end
        end else begin
            w_cb6 = r_cb5;
            w_cr6 = r_cr5;
        end
    end

    // S6 output register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_y6  <= 10'd0;
            r_cb6 <= 10'd0;
            r_cr6 <= 10'd0;
        end else if (r_live[4]) begin
            r_y6  <= r_y5;
            r_cb6 <= w_cb6;
            r_cr6 <= w_cr6;
        end else begin
            r_y6  <= 10'd0;
            r_cb6 <= 10'd0;
            r_cr6 <= 10'd0;
        end
    end

    assign o_data_y  = r_y6;
    assign o_data_cb = r_cb6;
    assign o_data_cr = r_cr6;
    assign o_de      = r_de_d[5];
    assign o_sync_h  = r_hs_d[5];
    assign o_sync_v  = r_vs_d[5];

endmodule

// File: tb/tb_convert_rgb2ycbcr.sv
// Scoreboard bench for convert_rgb2ycbcr: one 4:4:4 and one 4:2:2 instance share
// stimulus; expectations come from the conversion formulas and an input-side phase model.
module tb_convert_rgb2ycbcr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_r = 8'd0, in_g = 8'd0, in_b = 8'd0;
    logic       in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
    logic [9:0] y0, cb0, cr0, y1, cb1, cr1;
    logic       de0, hs0, vs0, de1, hs1, vs1;

    typedef struct {
        int y;
        int cb;
        int cr;
        int de;
        int hs;
        int vs;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;
    bit   ph_odd = 1'b0;

    always #5 clk = ~clk;

    convert_rgb2ycbcr #(.CHROMA_422(1'b0)) u_dut444 (
        .i_clk(clk), .i_rst(rst_n),
        .i_data_r(in_r), .i_data_g(in_g), .i_data_b(in_b),
        .i_de(in_de), .i_sync_h(in_hs), .i_sync_v(in_vs),
        .o_data_y(y0), .o_data_cb(cb0), .o_data_cr(cr0),
        .o_de(de0), .o_sync_h(hs0), .o_sync_v(vs0)
    );

    convert_rgb2ycbcr #(.CHROMA_422(1'b1)) u_dut422 (
        .i_clk(clk), .i_rst(rst_n),
        .i_data_r(in_r), .i_data_g(in_g), .i_data_b(in_b),
        .i_de(in_de), .i_sync_h(in_hs), .i_sync_v(in_vs),
        .o_data_y(y1), .o_data_cb(cb1), .o_data_cr(cr1),
        .o_de(de1), .o_sync_h(hs1), .o_sync_v(vs1)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int sat10(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    function automatic exp_t model(input int rr, input int gg, input int bb,
                                   input int d, input int h, input int v);
        exp_t e;
        e.y  = sat10(64 + ((1052 * rr + 2065 * gg + 401 * bb + 512) >>> 10));
        e.cb = sat10(512 + ((-607 * rr - 1192 * gg + 1799 * bb + 512) >>> 10));
        e.cr = sat10(512 + ((1799 * rr - 1506 * gg - 293 * bb + 512) >>> 10));
        e.de = d;
        e.hs = h;
        e.vs = v;
        return e;
    endfunction

    task automatic cmp_out(input string who, input exp_t e,
                           input int y, input int cb, input int cr,
                           input int d, input int h, input int v);
        chk({who, "_y"}, y, e.y);
        chk({who, "_cb"}, cb, e.cb);
        chk({who, "_cr"}, cr, e.cr);
        chk({who, "_de"}, d, e.de);
        chk({who, "_hs"}, h, e.hs);
        chk({who, "_vs"}, v, e.vs);
    endtask

    task automatic prefill();
        exp_t z;
        z = '{0, 0, 0, 0, 0, 0};
        q0.delete();
        q1.delete();
        ph_odd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            q0.push_back(z);
            q1.push_back(z);
        end
    endtask

    // Drive one pixel, push expectations, clock once and compare whatever is due.
    task automatic step(input int rr, input int gg, input int bb,
                        input bit d, input bit h, input bit v);
        exp_t e0, e1, p;
        int   a;
        in_r  = rr[7:0];
        in_g  = gg[7:0];
        in_b  = bb[7:0];
        in_de = d;
        in_hs = h;
        in_vs = v;
        e0 = model(rr, gg, bb, int'(d), int'(h), int'(v));
        e1 = e0;
        if (ph_odd && d) begin
            p = q1[q1.size() - 1];
            a = (p.cb + e1.cb + 1) >> 1;
            p.cb = a;
            e1.cb = a;
            a = (p.cr + e1.cr + 1) >> 1;
            p.cr = a;
            e1.cr = a;
            q1[q1.size() - 1] = p;
        end
        if (h || !d) ph_odd = 1'b0;
        else         ph_odd = !ph_odd;
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        @(negedge clk);
        if (q0.size() == 6) begin
            e0 = q0.pop_front();
            cmp_out("p444", e0, int'(y0), int'(cb0), int'(cr0), int'(de0), int'(hs0), int'(vs0));
        end
        if (q1.size() == 6) begin
            e1 = q1.pop_front();
            cmp_out("p422", e1, int'(y1), int'(cb1), int'(cr1), int'(de1), int'(hs1), int'(vs1));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_y0"}, int'(y0), 0);
        chk({tag, "_cb0"}, int'(cb0), 0);
        chk({tag, "_cr0"}, int'(cr0), 0);
        chk({tag, "_ctl0"}, int'({de0, hs0, vs0}), 0);
        chk({tag, "_y1"}, int'(y1), 0);
        chk({tag, "_cb1"}, int'(cb1), 0);
        chk({tag, "_cr1"}, int'(cr1), 0);
        chk({tag, "_ctl1"}, int'({de1, hs1, vs1}), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        prefill();

        // White then black, primaries.
        step(255, 255, 255, 1'b1, 1'b0, 1'b0);
        step(0, 0, 0, 1'b1, 1'b0, 1'b0);
        step(255, 0, 0, 1'b1, 1'b0, 1'b0);
        step(0, 0, 255, 1'b1, 1'b0, 1'b0);
        // Sync pulses on distinct cycles.
        step(10, 20, 30, 1'b1, 1'b1, 1'b0);
        step(40, 50, 60, 1'b1, 1'b0, 1'b0);
        step(70, 80, 90, 1'b1, 1'b0, 1'b1);
        idle(6);
        // Blue/yellow pair, then blue, blue, red burst.
        step(0, 0, 255, 1'b1, 1'b0, 1'b0);
        step(255, 255, 0, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(0, 0, 255, 1'b1, 1'b0, 1'b0);
        step(0, 0, 255, 1'b1, 1'b0, 1'b0);
        step(255, 0, 0, 1'b1, 1'b0, 1'b0);
        idle(2);
        // Sync_h on an even pixel breaks the pair.
        step(200, 10, 50, 1'b1, 1'b1, 1'b0);
        step(5, 250, 90, 1'b1, 1'b0, 1'b0);
        step(120, 60, 30, 1'b1, 1'b0, 1'b0);
        idle(3);
        random_run(300);

        // Asynchronous reset mid-burst.
        step(255, 255, 255, 1'b1, 1'b0, 1'b0);
        step(30, 200, 100, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("arst");
        in_de = 1'b0;
        in_hs = 1'b0;
        in_vs = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("arst_hold");
        rst_n = 1'b1;
        prefill();
        step(0, 255, 0, 1'b1, 1'b0, 1'b0);
        step(255, 0, 255, 1'b1, 1'b0, 1'b0);
        random_run(100);
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
